// File: rtl/fetch_queue_pkg.sv
// fetch_queue_pkg: shared constants, queue entry type and dequeue-request helper
package fetch_queue_pkg;
  localparam logic [31:0] NOP_INSTR = 32'h0;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam int FETCH_WIDTH = 2;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pcplus4;
  } fq_entry_t;

  // decode may never take more than FETCH_WIDTH entries; 3 is folded to 2
  function automatic logic [1:0] deq_req(input logic [1:0] d);
    return d == 2'd3 ? 2'(FETCH_WIDTH) : d;
  endfunction
endpackage

// File: rtl/fetch_queue_if.sv
// fetch_queue_if: imem fetch port plus decode-side slots and redirect
interface fetch_queue_if #(
  parameter int DEPTH = 8
);
  localparam int CW = $clog2(DEPTH) + 1;
  logic          redirect;
  logic [31:0]   redirect_pc;
  logic [31:0]   imem_addr;
  logic [31:0]   imem_rdata0;
  logic [31:0]   imem_rdata1;
  logic [1:0]    deq_count;
  logic [1:0]    out_valid;
  logic [31:0]   out_instr0;
  logic [31:0]   out_pcplus4_0;
  logic [31:0]   out_instr1;
  logic [31:0]   out_pcplus4_1;
  logic [CW-1:0] count;

  modport master (
    output redirect, redirect_pc, imem_rdata0, imem_rdata1, deq_count,
    input  imem_addr, out_valid, out_instr0, out_pcplus4_0, out_instr1, out_pcplus4_1, count
  );

  modport slave (
    input  redirect, redirect_pc, imem_rdata0, imem_rdata1, deq_count,
    output imem_addr, out_valid, out_instr0, out_pcplus4_0, out_instr1, out_pcplus4_1, count
  );
endinterface

// File: rtl/fetch_queue_mem.sv
// fetch_queue_mem: DEPTH-entry storage, two write ports and two combinational read ports
module fetch_queue_mem
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we0,
  input  logic          we1,
  input  logic [AW-1:0] waddr0,
  input  logic [AW-1:0] waddr1,
  input  fq_entry_t     wdata0,
  input  fq_entry_t     wdata1,
  input  logic [AW-1:0] raddr0,
  input  logic [AW-1:0] raddr1,
  output fq_entry_t     rdata0,
  output fq_entry_t     rdata1
);
  fq_entry_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we0) mem[waddr0] <= wdata0;
    if (we1) mem[waddr1] <= wdata1;
  end

  assign rdata0 = mem[raddr0];
  assign rdata1 = mem[raddr1];
endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: owns the fetch PC and a circular queue of {instr, pcplus4} pairs
// feeding up to two entries per cycle to decode; redirect flushes and refetches.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int          DEPTH    = 8,
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input logic          clk,
  input logic          reset,
  fetch_queue_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL     = CW'(DEPTH);
  localparam logic [CW-1:0] ONE_LEFT = CW'(DEPTH - 1);

  logic [AW-1:0] head, tail;
  logic [CW-1:0] cnt;
  logic [31:0]   pc;
  logic [1:0]    enq, req, deq;
  logic          we0, we1, v0, v1;
  fq_entry_t     wdata0, wdata1, rdata0, rdata1;

  // enqueue sized on the pre-dequeue count so a write never overruns the head
  always_comb begin
    enq    = cnt == FULL ? 2'd0 : cnt == ONE_LEFT ? 2'd1 : 2'(FETCH_WIDTH);
    req    = deq_req(bus.deq_count);
    deq    = CW'(req) > cnt ? cnt[1:0] : req;
    we0    = !bus.redirect && enq != 2'd0;
    we1    = !bus.redirect && enq == 2'd2;
    wdata0 = {bus.imem_rdata0, pc + 32'd4};
    wdata1 = {bus.imem_rdata1, pc + 32'd8};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
      pc   <= RESET_PC & ~32'h3;
    end else if (bus.redirect) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
      pc   <= bus.redirect_pc & ~32'h3;
    end else begin
      head <= head + AW'(deq);
      tail <= tail + AW'(enq);
      cnt  <= cnt + CW'(enq) - CW'(deq);
      pc   <= pc + 32'({enq, 2'b00});
    end
  end

  fetch_queue_mem #(.DEPTH(DEPTH), .AW(AW)) u_mem (
    .clk    (clk),
    .we0    (we0),
    .we1    (we1),
    .waddr0 (tail),
    .waddr1 (tail + AW'(1)),
    .wdata0 (wdata0),
    .wdata1 (wdata1),
    .raddr0 (head),
    .raddr1 (head + AW'(1)),
    .rdata0 (rdata0),
    .rdata1 (rdata1)
  );

  assign v0                = cnt != '0;
  assign v1                = cnt > CW'(1);
  assign bus.imem_addr     = pc;
  assign bus.count         = cnt;
  assign bus.out_valid     = {v1, v0};
  assign bus.out_instr0    = v0 ? rdata0.instr : NOP_INSTR;
  assign bus.out_pcplus4_0 = v0 ? rdata0.pcplus4 : 32'h0;
  assign bus.out_instr1    = v1 ? rdata1.instr : NOP_INSTR;
  assign bus.out_pcplus4_1 = v1 ? rdata1.pcplus4 : 32'h0;
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: vector table, hand sequences for wrap/reset, and a queue-based
// reference model under random deq_count/redirect traffic.
module tb_fetch_queue;
  localparam int DEPTH = 8;

  typedef struct packed {
    logic [1:0]  deq;
    logic        redir;
    logic [31:0] rpc;
    logic [3:0]  cnt;
    logic [1:0]  vld;
    logic [31:0] i0, p0, i1, p1, addr;
  } vec_t;

  typedef struct packed {
    logic [31:0] i;
    logic [31:0] p;
  } ent_t;

  logic clk = 0;
  logic reset = 0;
  int checks = 0;
  int passed = 0;
  vec_t tbl [16];
  ent_t q[$];
  logic [31:0] mpc;

  fetch_queue_if #(.DEPTH(DEPTH)) bus ();

  fetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word(input logic [31:0] a);
    return (a >> 2) + 32'd100;
  endfunction

  assign bus.imem_rdata0 = word(bus.imem_addr);
  assign bus.imem_rdata1 = word(bus.imem_addr + 32'd4);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic chk_all(input string nm, input logic [3:0] c, input logic [1:0] v,
                         input logic [31:0] i0, p0, i1, p1, addr);
    chk({nm, ".count"}, 32'(bus.count), 32'(c));
    chk({nm, ".valid"}, 32'(bus.out_valid), 32'(v));
    chk({nm, ".instr0"}, bus.out_instr0, i0);
    chk({nm, ".pcplus4_0"}, bus.out_pcplus4_0, p0);
    chk({nm, ".instr1"}, bus.out_instr1, i1);
    chk({nm, ".pcplus4_1"}, bus.out_pcplus4_1, p1);
    chk({nm, ".imem_addr"}, bus.imem_addr, addr);
  endtask

  task automatic do_reset();
    reset = 0;
    bus.deq_count = 0;
    bus.redirect = 0;
    bus.redirect_pc = 0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1;
    q.delete();
    mpc = 32'h0;
  endtask

  task automatic model_step(input int d, input bit r, input logic [31:0] rpc);
    int n, e, dd;
    n = q.size();
    e = n <= DEPTH - 2 ? 2 : (n == DEPTH - 1 ? 1 : 0);
    dd = d > 2 ? 2 : d;
    if (dd > n) dd = n;
    if (r) begin
      q.delete();
      mpc = rpc & ~32'h3;
    end else begin
      repeat (dd) void'(q.pop_front());
      for (int k = 0; k < e; k++) begin
        q.push_back({word(mpc), mpc + 32'd4});
        mpc += 32'd4;
      end
    end
  endtask

  task automatic chk_model(input string nm);
    ent_t e0, e1;
    int n;
    n = q.size();
    e0 = '0;
    e1 = '0;
    if (n >= 1) e0 = q[0];
    if (n >= 2) e1 = q[1];
    chk_all(nm, 4'(n), {n >= 2, n >= 1}, e0.i, e0.p, e1.i, e1.p, mpc);
  endtask

  initial begin
    int d;
    bit r;
    logic [31:0] rpc;
    //          deq  rd rpc           cnt vld i0   p0     i1   p1     addr
    tbl[0]  = '{2'd0, 0, 32'h0,  4'd0, 2'b00, 0,   0,     0,   0,     32'h00};
    tbl[1]  = '{2'd0, 0, 32'h0,  4'd2, 2'b11, 100, 4,     101, 8,     32'h08};
    tbl[2]  = '{2'd0, 0, 32'h0,  4'd4, 2'b11, 100, 4,     101, 8,     32'h10};
    tbl[3]  = '{2'd0, 0, 32'h0,  4'd6, 2'b11, 100, 4,     101, 8,     32'h18};
    tbl[4]  = '{2'd0, 0, 32'h0,  4'd8, 2'b11, 100, 4,     101, 8,     32'h20};
    tbl[5]  = '{2'd2, 0, 32'h0,  4'd8, 2'b11, 100, 4,     101, 8,     32'h20};
    tbl[6]  = '{2'd0, 0, 32'h0,  4'd6, 2'b11, 102, 12,    103, 16,    32'h20};
    tbl[7]  = '{2'd3, 0, 32'h0,  4'd8, 2'b11, 102, 12,    103, 16,    32'h28};
    tbl[8]  = '{2'd1, 0, 32'h0,  4'd6, 2'b11, 104, 20,    105, 24,    32'h28};
    tbl[9]  = '{2'd0, 0, 32'h0,  4'd7, 2'b11, 105, 24,    106, 28,    32'h30};
    tbl[10] = '{2'd2, 1, 32'h43, 4'd8, 2'b11, 105, 24,    106, 28,    32'h34};
    tbl[11] = '{2'd2, 0, 32'h0,  4'd0, 2'b00, 0,   0,     0,   0,     32'h40};
    tbl[12] = '{2'd2, 0, 32'h0,  4'd2, 2'b11, 116, 32'h44, 117, 32'h48, 32'h48};
    tbl[13] = '{2'd2, 0, 32'h0,  4'd2, 2'b11, 118, 32'h4c, 119, 32'h50, 32'h50};
    tbl[14] = '{2'd1, 0, 32'h0,  4'd2, 2'b11, 120, 32'h54, 121, 32'h58, 32'h58};
    tbl[15] = '{2'd0, 0, 32'h0,  4'd3, 2'b11, 121, 32'h58, 122, 32'h5c, 32'h60};

    do_reset();
    for (int i = 0; i < 16; i++) begin
      chk_all($sformatf("vec%0d", i), tbl[i].cnt, tbl[i].vld, tbl[i].i0, tbl[i].p0,
              tbl[i].i1, tbl[i].p1, tbl[i].addr);
      bus.deq_count = tbl[i].deq;
      bus.redirect = tbl[i].redir;
      bus.redirect_pc = tbl[i].rpc;
      tick();
    end
    bus.redirect = 0;
    bus.deq_count = 0;

    // walk head to index 6 while full, then drain across the wrap point
    do_reset();
    repeat (4) tick();
    for (int k = 0; k < 3; k++) begin
      bus.deq_count = 2;
      tick();
      bus.deq_count = 0;
      tick();
    end
    chk("wrap.count", 32'(bus.count), 32'd8);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("wrap%0d.instr0", k), bus.out_instr0, 32'(106 + 2 * k));
      chk($sformatf("wrap%0d.instr1", k), bus.out_instr1, 32'(107 + 2 * k));
      chk($sformatf("wrap%0d.pcplus4_1", k), bus.out_pcplus4_1, 32'((7 + 2 * k) * 4 + 4));
      bus.deq_count = 2;
      tick();
    end
    bus.deq_count = 0;

    // asynchronous reset mid-cycle
    do_reset();
    repeat (3) tick();
    chk("arst.pre_count", 32'(bus.count), 32'd6);
    #2;
    reset = 0;
    #1;
    chk_all("arst", 4'd0, 2'b00, 0, 0, 0, 0, 32'h0);
    @(negedge clk);
    reset = 1;

    do_reset();
    for (int n = 0; n < 300; n++) begin
      chk_model($sformatf("rnd%0d", n));
      d = int'($urandom_range(3));
      r = $urandom_range(11) == 0;
      rpc = $urandom_range(3) == 0 ? 32'hFFFF_FFF0 + 32'($urandom_range(15)) : $urandom;
      bus.deq_count = 2'(d);
      bus.redirect = r;
      bus.redirect_pc = rpc;
      tick();
      model_step(d, r, rpc);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Dual-issue fetch front end: owns the fetch PC and a circular instruction queue between inst_memory and the decode pipeline register.
- Each cycle it fetches up to two consecutive words. It buffers {instr, pcplus4} pairs and presents the two oldest entries to decode.
- Decode consumes 0, 1 or 2 entries per cycle.
- A taken branch or jump in decode redirects the PC and flushes the queue.

Parameters:
DEPTH, 8, queue entries; power of two, >= 4
RESET_PC, 32'h0000_0000, fetch PC after reset

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-low reset (asserted when 0)
redirect  in  1  decode resolved taken branch/jump (pcsrcD != 0)
redirect_pc  in  32  target PC (pcbranchD or pcjumpD)
imem_addr  out  32  fetch PC; imem returns words at imem_addr and imem_addr+4
imem_rdata0  in  32  combinational instruction at imem_addr
imem_rdata1  in  32  combinational instruction at imem_addr+4
deq_count  in  2  entries decode consumes this cycle (0..2; 3 illegal)
out_valid  out  2  bit0: slot0 valid; bit1: slot1 valid
out_instr0  out  32  oldest instruction
out_pcplus4_0  out  32  its PC+4
out_instr1  out  32  second-oldest instruction
out_pcplus4_1  out  32  its PC+4
count  out  $clog2(DEPTH)+1  occupied entries

Behaviour:
- Reset (reset=0, asynchronous):
  - pc=RESET_PC; head=tail=0; count=0; out_valid=0.
  - Storage contents don't care.
  - A mid-operation reset discards everything immediately.
- imem_addr = pc, combinational from the register; bits [1:0] are always 0.
- Enqueue amount is computed from count at the start of the cycle (pre-dequeue, conservative):
  - count <= DEPTH-2: enq=2. Write {imem_rdata0, pc+4} at tail and {imem_rdata1, pc+8} at tail+1 (mod DEPTH). pc <= pc+8.
  - count == DEPTH-1: enq=1. Write {imem_rdata0, pc+4} at tail. pc <= pc+4.
  - count == DEPTH: enq=0; pc holds.
- Dequeue:
  - deq = min(deq_count, count); a value of 3 is treated as 2 and then clamped.
  - head <= head+deq (mod DEPTH).
- Counters: count <= count + enq - deq in the same cycle, no bypass.
  - An entry enqueued in cycle N is visible on the outputs in N+1 at the earliest.
  - Fetch-to-decode latency is 1 cycle.
- Outputs (combinational from state):
  - slot0 = entry[head]; slot1 = entry[head+1 mod DEPTH].
  - out_valid[0] = count>=1; out_valid[1] = count>=2.
  - Any slot whose valid bit is low drives instr = 32'h0 (NOP) and pcplus4 = 0.
- Redirect (has priority over everything):
  - head=tail=0; count=0; pc <= {redirect_pc[31:2], 2'b00}.
  - No enqueue and no dequeue take effect that cycle.
  - The next cycle fetches from the target; its first instruction is valid the cycle after that.
- Wrap-around: pointers are $clog2(DEPTH) bits and wrap naturally. Two-entry writes and reads may straddle index DEPTH-1 -> 0.
- PC overflow: pc wraps mod 2^32, with no error.
- Full with deq=2: enq=0 that cycle and count drops to DEPTH-2. The next cycle enqueues 2.

Decomposition:
- Shared package constants: NOP_INSTR = 32'h0, RESET_PC default, FETCH_WIDTH = 2.
- One sub-module, fetch_queue_mem:
  - DEPTH x 64-bit register array with two write ports (tail, tail+1) and two combinational read ports (head, head+1).
  - Per-port write enables.
  - No reset on the storage.
- Pointer, count and PC logic stay in fetch_queue.

Test Plan:
- Reset, then imem at word i = i+100, deq_count=0 -> after 4 cycles: count=8, imem_addr=32 holds, slot0=100/pcplus4=4, slot1=101/8.
- Steady state deq_count=2 from empty -> from cycle 2 onward out_valid=2'b11 every cycle, with instructions 100,101,102,103... in order and no gaps.
- Fill to 7 (DEPTH=8) with deq_count=0 -> exactly one enqueue, pc advances by 4, count=8, then stalls.
- Wrap check: head=6, tail=6, count=8, deq_count=2 for 4 cycles -> slots read index pairs (6,7), (0,1), ... with correct order across the wrap.
- Redirect with redirect_pc=32'h0000_0043 while count=5 and deq_count=2 -> next cycle count=0, out_valid=0, outputs NOP, imem_addr=32'h40; following cycle count=2 with the instructions at 0x40 and 0x44.
- Assert reset mid-run with count=6 -> outputs go to 0 and imem_addr=RESET_PC immediately, without waiting for a clock edge.
- deq_count=2 with count=1 -> only one entry is removed, count=0 (clamp); a concurrent enqueue of 2 gives count=2.
